icache_direct_mapped: RTL and testbench

// - Direct-mapped instruction cache; sits directly upstream of memory_controller on the I-side.
// - Serves 32-bit instruction fetches from the fetch stage. On a miss it requests a 128-bit line

---
 rtl/icache_pkg.sv | 29 ++
 rtl/icache_array.sv | 56 +++++
 rtl/icache_direct_mapped.sv | 122 ++++++++++++
 tb/tb_icache_direct_mapped.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, widths and constants for the direct-mapped I-cache
package icache_pkg;

    localparam int LINE_BITS     = 128;
    localparam int MADDR_BITS    = 26;
    localparam int WORD_BITS     = 32;
    localparam int WSEL_BITS     = 2;
    localparam int NUM_LINES_DEF = 4;

    // The line address is pc[29:4]; the index takes the low bits of it
    // and the tag takes whatever is left.
    function automatic int idx_bits(input int num_lines);
        return (num_lines > 1) ? $clog2(num_lines) : 1;
    endfunction

    function automatic int tag_bits(input int num_lines);
        return MADDR_BITS - idx_bits(num_lines);
    endfunction

    localparam int IDX_BITS_DEF = idx_bits(NUM_LINES_DEF);
    localparam int TAG_BITS_DEF = tag_bits(NUM_LINES_DEF);

    typedef enum logic [1:0] {
        IDLE,
        MISS_WAIT,
        REFILL
    } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data storage for the direct-mapped I-cache
//
// Ports:
//   clk, reset     clock and synchronous active-high reset (clears valid bits only)
//   rd_index_i     combinational read index
//   rd_valid_o     valid bit at rd_index_i
//   rd_tag_o       stored tag at rd_index_i
//   rd_line_o      stored line at rd_index_i
//   we_i           write enable: installs wr_tag_i/wr_line_i at wr_index_i and sets valid
//   wr_index_i     write index
//   wr_tag_i       tag to install
//   wr_line_i      line to install
module icache_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES = NUM_LINES_DEF,
    parameter int IDX_W     = idx_bits(NUM_LINES),
    parameter int TAG_W     = tag_bits(NUM_LINES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     rd_index_i,
    output logic                 rd_valid_o,
    output logic [TAG_W-1:0]     rd_tag_o,
    output logic [LINE_BITS-1:0] rd_line_o,
    input  logic                 we_i,
    input  logic [IDX_W-1:0]     wr_index_i,
    input  logic [TAG_W-1:0]     wr_tag_i,
    input  logic [LINE_BITS-1:0] wr_line_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data carry no reset; the valid bit alone guards them.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_line_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_line_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - direct-mapped read-only instruction cache with line refill
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   fetch_req               fetch stage requests the instruction at fetch_pc
//   fetch_pc                byte address; bits [1:0] and [31:30] are ignored
//   fetch_instr             instruction, zero-latency on a hit, zero otherwise
//   fetch_stall             request not served this cycle; fetch holds fetch_pc
//   reqI_cache              line request to the memory controller
//   reqAddrI_mem            requested line address (fetch_pc[29:4] of the miss)
//   read_ready_for_icache   one-cycle pulse; data_to_cache holds the requested line
//   data_to_cache           refill line, shared with the D-side
module icache_direct_mapped
    import icache_pkg::*;
#(
    parameter int NUM_LINES = NUM_LINES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_pc,
    output logic [WORD_BITS-1:0]  fetch_instr,
    output logic                  fetch_stall,
    output logic                  reqI_cache,
    output logic [MADDR_BITS-1:0] reqAddrI_mem,
    input  logic                  read_ready_for_icache,
    input  logic [LINE_BITS-1:0]  data_to_cache
);

    localparam int IDX_W = idx_bits(NUM_LINES);
    localparam int TAG_W = tag_bits(NUM_LINES);

    icache_state_t         state_q, state_d;
    logic [MADDR_BITS-1:0] miss_addr_q, miss_addr_d;
    logic                  req_q, req_d;
    logic                  fill_we;

    logic [WSEL_BITS-1:0]  pc_word;
    logic [IDX_W-1:0]      pc_index;
    logic [TAG_W-1:0]      pc_tag;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [LINE_BITS-1:0]  rd_line;
    logic                  hit;
    logic                  unused_pc_bits;

    assign pc_word        = fetch_pc[3:2];
    assign pc_index       = fetch_pc[4 +: IDX_W];
    assign pc_tag         = fetch_pc[29 -: TAG_W];
    assign unused_pc_bits = ^{fetch_pc[31:30], fetch_pc[1:0]};

    icache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .rd_index_i (pc_index),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        // A ready pulse coinciding with reset must not install the line.
        .we_i       (fill_we & ~reset),
        .wr_index_i (miss_addr_q[IDX_W-1:0]),
        .wr_tag_i   (miss_addr_q[MADDR_BITS-1 -: TAG_W]),
        .wr_line_i  (data_to_cache)
    );

    // Lookups only count in IDLE: during REFILL the freshly written line is
    // already visible, but the extra stall cycle is part of the miss timing.
    assign hit         = fetch_req & (state_q == IDLE) & rd_valid & (rd_tag == pc_tag);
    assign fetch_stall = fetch_req & ~hit;
    assign fetch_instr = hit ? rd_line[WORD_BITS*pc_word +: WORD_BITS] : '0;

    assign reqI_cache   = req_q;
    assign reqAddrI_mem = miss_addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            req_q       <= req_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        req_d       = req_q;
        fill_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_req && !hit) begin
                    miss_addr_d = fetch_pc[29:4];
                    req_d       = 1'b1;
                    state_d     = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                // Request stays up for as long as the controller serves the D-side.
                if (read_ready_for_icache) begin
                    fill_we = 1'b1;
                    req_d   = 1'b0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb/tb_icache_direct_mapped.sv - randomized self-checking bench for icache_direct_mapped
module tb_icache_direct_mapped;

    logic         clk = 1'b0;
    logic         reset;
    logic         fetch_req;
    logic [31:0]  fetch_pc;
    logic [31:0]  fetch_instr;
    logic         fetch_stall;
    logic         reqI_cache;
    logic [25:0]  reqAddrI_mem;
    logic         read_ready_for_icache;
    logic [127:0] data_to_cache;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one entry per cache line, indexed by pc[5:4].
    bit           valid_m [4];
    logic [23:0]  tag_m   [4];
    logic [127:0] data_m  [4];

    always #5 clk = ~clk;

    icache_direct_mapped dut (
        .clk                   (clk),
        .reset                 (reset),
        .fetch_req             (fetch_req),
        .fetch_pc              (fetch_pc),
        .fetch_instr           (fetch_instr),
        .fetch_stall           (fetch_stall),
        .reqI_cache            (reqI_cache),
        .reqAddrI_mem          (reqAddrI_mem),
        .read_ready_for_icache (read_ready_for_icache),
        .data_to_cache         (data_to_cache)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] mem_line(input logic [25:0] la);
        logic [31:0] s;
        s = {6'b0, la};
        return {s * 32'h9E3779B1 ^ 32'h4, s * 32'h85EBCA6B ^ 32'h3,
                s * 32'hC2B2AE35 ^ 32'h2, s * 32'h27D4EB2F ^ 32'h1};
    endfunction

    function automatic logic [127:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) valid_m[i] = 1'b0;
    endtask

    // Entered and left at posedge+1. Misses are served with the given line after
    // the given number of wait cycles in which the controller is busy elsewhere.
    task automatic fetch(input logic [31:0] pc, input logic [127:0] line, input int delay);
        int          idx;
        int          w;
        logic [23:0] tg;
        bit          hit_exp;
        idx = int'(pc[5:4]);
        w   = int'(pc[3:2]);
        tg  = pc[29:6];
        fetch_req = 1'b1;
        fetch_pc  = pc;
        @(negedge clk);
        hit_exp = valid_m[idx] && (tag_m[idx] == tg);
        check("lookup_stall", fetch_stall, !hit_exp);
        if (hit_exp) begin
            check("hit_instr", fetch_instr, data_m[idx][32*w +: 32]);
        end else begin
            check("miss_instr", fetch_instr, 0);
            @(posedge clk); #1;
            check("req_asserted", reqI_cache, 1);
            check("req_addr", reqAddrI_mem, pc[29:4]);
            for (int d = 0; d < delay; d++) begin
                data_to_cache = junk();
                @(negedge clk);
                check("req_hold", reqI_cache, 1);
                check("addr_hold", reqAddrI_mem, pc[29:4]);
                check("wait_stall", fetch_stall, 1);
                @(posedge clk); #1;
            end
            read_ready_for_icache = 1'b1;
            data_to_cache         = line;
            @(posedge clk); #1;
            read_ready_for_icache = 1'b0;
            data_to_cache         = junk();
            valid_m[idx] = 1'b1;
            tag_m[idx]   = tg;
            data_m[idx]  = line;
            @(negedge clk);
            check("refill_stall", fetch_stall, 1);
            check("req_dropped", reqI_cache, 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("post_fill_stall", fetch_stall, 0);
            check("post_fill_instr", fetch_instr, line[32*w +: 32]);
        end
        @(posedge clk); #1;
        fetch_req = 1'b0;
    endtask

    initial begin
        logic [127:0] line40;
        logic [31:0]  words40 [4];
        logic [31:0]  pc;
        logic [25:0]  la;

        line40 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        words40[0] = 32'h1111_1111;
        words40[1] = 32'h2222_2222;
        words40[2] = 32'h3333_3333;
        words40[3] = 32'h4444_4444;

        reset                 = 1'b1;
        fetch_req             = 1'b0;
        fetch_pc              = 32'h0;
        read_ready_for_icache = 1'b0;
        data_to_cache         = '0;
        model_reset();
        repeat (3) @(posedge clk);

        // Reset values
        @(negedge clk);
        check("rst_req", reqI_cache, 0);
        check("rst_addr", reqAddrI_mem, 0);
        check("rst_stall_idle", fetch_stall, 0);
        check("rst_instr", fetch_instr, 0);
        fetch_req = 1'b1;
        fetch_pc  = 32'h40;
        #1;
        check("rst_stall_req", fetch_stall, 1);
        check("rst_instr_req", fetch_instr, 0);
        @(posedge clk); #1;
        reset     = 1'b0;
        fetch_req = 1'b0;

        // Stray ready in IDLE must not install anything
        read_ready_for_icache = 1'b1;
        data_to_cache         = 128'hDEAD;
        @(negedge clk);
        check("stray_no_req", reqI_cache, 0);
        @(posedge clk); #1;
        read_ready_for_icache = 1'b0;

        // Cold miss at 0x40, 10-cycle controller latency
        fetch(32'h40, line40, 10);
        for (int w = 0; w < 4; w++) begin
            fetch_req = 1'b1;
            fetch_pc  = 32'h40 + 32'(4 * w);
            @(negedge clk);
            check("line40_word", fetch_instr, words40[w]);
            check("line40_stall", fetch_stall, 0);
            @(posedge clk); #1;
        end
        fetch_req = 1'b0;

        // Conflict eviction on index 0
        fetch(32'h80, mem_line(26'h8), 4);
        fetch(32'h40, line40, 3);

        // Long D-side priority wait
        fetch(32'hC0, mem_line(26'hC), 30);
        fetch(32'hC4, mem_line(26'hC), 0);

        // Reset in the middle of a miss
        fetch_req = 1'b1;
        fetch_pc  = 32'h200;
        @(negedge clk);
        check("mid_stall", fetch_stall, 1);
        @(posedge clk); #1;
        check("mid_req_up", reqI_cache, 1);
        reset     = 1'b1;
        fetch_req = 1'b0;
        @(posedge clk); #1;
        check("mid_req_drop", reqI_cache, 0);
        check("mid_addr_clr", reqAddrI_mem, 0);
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        read_ready_for_icache = 1'b1;
        data_to_cache         = mem_line(26'h20);
        @(posedge clk); #1;
        read_ready_for_icache = 1'b0;
        fetch(32'h200, mem_line(26'h20), 2);
        fetch(32'h40, line40, 1);

        // Randomized traffic over 16 lines competing for 4 sets
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                fetch_req             = 1'b0;
                fetch_pc              = $urandom;
                read_ready_for_icache = 1'($urandom_range(0, 1));
                data_to_cache         = junk();
                @(negedge clk);
                check("idle_stall", fetch_stall, 0);
                check("idle_instr", fetch_instr, 0);
                check("idle_req", reqI_cache, 0);
                @(posedge clk); #1;
                read_ready_for_icache = 1'b0;
            end else begin
                la       = 26'($urandom_range(0, 15));
                pc       = $urandom;
                pc[29:4] = la;
                fetch(pc, mem_line(la), int'($urandom_range(0, 6)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
